// File: rtl/hit_pkg.sv
// Shared types for the hit timestamper: the hit record layout and the pulse FSM states.
package hit_pkg;

  localparam int unsigned HIT_TS_WIDTH  = 32;
  localparam int unsigned HIT_TOT_WIDTH = 8;

  typedef struct packed {
    logic [HIT_TS_WIDTH-1:0]  timestamp;
    logic [HIT_TOT_WIDTH-1:0] tot;
    logic                     saturated;
  } hit_t;

  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  // Flat record width for a given timestamp/TOT sizing.
  function automatic int unsigned hit_width(input int unsigned ts_w, input int unsigned tot_w);
    return ts_w + tot_w + 1;
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is accepted when a pop happens that cycle.
module hit_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/hit_timestamper.sv
// Detects pulses on a synchronized discriminator level and queues {rise timestamp, TOT,
// saturated} records for readout over a valid/ready handshake.
module hit_timestamper
  import hit_pkg::*;
#(
  parameter int unsigned TS_WIDTH   = 32,
  parameter int unsigned TOT_WIDTH  = 8,
  parameter int unsigned MIN_TOT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_level,
  input  logic                 i_enable,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [TS_WIDTH-1:0]  o_timestamp,
  output logic [TOT_WIDTH-1:0] o_tot,
  output logic                 o_saturated,
  output logic [15:0]          o_drop_count,
  output logic                 o_busy
);

  localparam int unsigned REC_W = hit_width(TS_WIDTH, TOT_WIDTH);
  localparam logic [TOT_WIDTH-1:0] TOT_MAX   = '1;
  localparam logic [TOT_WIDTH-1:0] MIN_TOT_V = TOT_WIDTH'(MIN_TOT);

  state_t               state_q;
  logic [TS_WIDTH-1:0]  ts_now_q, cap_ts_q;
  logic [TOT_WIDTH-1:0] tot_q;
  logic                 sat_q;
  logic                 level_d_q;
  logic [15:0]          drop_cnt_q;

  logic             rise, push, pop, fifo_full, fifo_empty;
  logic [REC_W-1:0] rec_in, rec_out;

  assign rise = i_level & ~level_d_q;
  // Abort (i_enable low) wins over a falling edge, so a push needs enable still high.
  assign push = (state_q == HIGH) & i_enable & ~i_level & (tot_q >= MIN_TOT_V);
  assign pop  = o_valid & i_ready;

  assign rec_in = {cap_ts_q, tot_q, sat_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_now_q  <= '0;
      level_d_q <= 1'b1;  // a level already high out of reset is not an edge
      state_q   <= IDLE;
      cap_ts_q  <= '0;
      tot_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      ts_now_q  <= ts_now_q + TS_WIDTH'(1);
      level_d_q <= i_level;
      unique case (state_q)
        IDLE: begin
          if (rise && i_enable) begin
            state_q  <= HIGH;
            cap_ts_q <= ts_now_q;
            tot_q    <= TOT_WIDTH'(1);
            sat_q    <= 1'b0;
          end
        end
        HIGH: begin
          if (!i_enable || !i_level) begin
            state_q <= IDLE;
          end else if (tot_q == TOT_MAX) begin
            sat_q <= 1'b1;
          end else begin
            tot_q <= tot_q + TOT_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (push && fifo_full && !pop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  hit_fifo #(
    .WIDTH(REC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .data_i (rec_in),
    .pop_i  (pop),
    .data_o (rec_out),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign o_valid      = ~fifo_empty;
  assign o_timestamp  = rec_out[REC_W-1 -: TS_WIDTH];
  assign o_tot        = rec_out[TOT_WIDTH:1];
  assign o_saturated  = rec_out[0];
  assign o_drop_count = drop_cnt_q;
  assign o_busy       = (state_q == HIGH);

endmodule

// File: tb/tb_hit_timestamper.sv
// Directed self-checking bench for hit_timestamper (TOT_WIDTH=4 so saturation is reachable).
module tb_hit_timestamper;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_level, i_enable, i_ready;
  logic        o_valid, o_saturated, o_busy;
  logic [31:0] o_timestamp;
  logic [3:0]  o_tot;
  logic [15:0] o_drop_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_ts;
  logic [31:0] exp_ts_q[$];
  logic [3:0]  exp_tot_q[$];
  logic [31:0] t;

  hit_timestamper #(
    .TS_WIDTH  (32),
    .TOT_WIDTH (4),
    .MIN_TOT   (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_level     (i_level),
    .i_enable    (i_enable),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_timestamp (o_timestamp),
    .o_tot       (o_tot),
    .o_saturated (o_saturated),
    .o_drop_count(o_drop_count),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  // Reference free-running counter: value of ts_now during the current cycle.
  always @(posedge clk) begin
    if (rst) model_ts <= 32'd0;
    else     model_ts <= model_ts + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Level high for n sampled cycles then low; returns the expected rise timestamp.
  task automatic pulse(input int n, output logic [31:0] ts);
    ts = model_ts;
    i_level = 1'b1;
    repeat (n) tick();
    i_level = 1'b0;
    tick();
  endtask

  task automatic queue_pulse(input int n);
    logic [31:0] ts;
    pulse(n, ts);
    exp_ts_q.push_back(ts);
    exp_tot_q.push_back(4'(n));
  endtask

  task automatic drain(input string tag);
    i_ready = 1'b1;
    while (exp_ts_q.size() > 0) begin
      check({tag, "_valid"}, 64'(o_valid), 64'(1));
      check({tag, "_ts"}, 64'(o_timestamp), 64'(exp_ts_q.pop_front()));
      check({tag, "_tot"}, 64'(o_tot), 64'(exp_tot_q.pop_front()));
      tick();
    end
    check({tag, "_empty"}, 64'(o_valid), 64'(0));
    i_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_level = 1'b0; i_enable = 1'b1; i_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_ts", 64'(o_timestamp), 64'(0));
    check("rst_tot", 64'(o_tot), 64'(0));
    check("rst_sat", 64'(o_saturated), 64'(0));
    check("rst_drop", 64'(o_drop_count), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    rst = 1'b0;

    // Single 5-cycle pulse, consumer ready.
    repeat (10) tick();
    i_ready = 1'b1;
    t = model_ts;
    i_level = 1'b1;
    tick();
    check("single_busy", 64'(o_busy), 64'(1));
    repeat (4) tick();
    i_level = 1'b0;
    tick();
    check("single_valid", 64'(o_valid), 64'(1));
    check("single_ts", 64'(o_timestamp), 64'(t));
    check("single_tot", 64'(o_tot), 64'(5));
    check("single_sat", 64'(o_saturated), 64'(0));
    tick();
    check("single_popped", 64'(o_valid), 64'(0));

    // Glitch filter: 1 cycle dropped, 2 cycles kept.
    pulse(1, t);
    check("glitch_valid", 64'(o_valid), 64'(0));
    check("glitch_drop", 64'(o_drop_count), 64'(0));
    tick();
    pulse(2, t);
    check("min_valid", 64'(o_valid), 64'(1));
    check("min_tot", 64'(o_tot), 64'(2));
    check("min_ts", 64'(o_timestamp), 64'(t));
    tick();

    // Saturation at 15, and exactly 15 cycles which is not saturated.
    pulse(20, t);
    check("sat_tot", 64'(o_tot), 64'(15));
    check("sat_flag", 64'(o_saturated), 64'(1));
    check("sat_ts", 64'(o_timestamp), 64'(t));
    tick();
    pulse(15, t);
    check("edge15_tot", 64'(o_tot), 64'(15));
    check("edge15_sat", 64'(o_saturated), 64'(0));
    tick();
    check("sat_drained", 64'(o_valid), 64'(0));

    // Backpressure: 6 pulses into depth 4, last two dropped.
    i_ready = 1'b0;
    for (int i = 2; i <= 5; i++) queue_pulse(i);
    pulse(6, t);
    pulse(7, t);
    check("bp_drop", 64'(o_drop_count), 64'(2));
    t = o_timestamp;
    tick();
    check("bp_hold_ts", 64'(o_timestamp), 64'(exp_ts_q[0]));
    drain("bp");

    // Full FIFO with a pop in the push cycle: push accepted, no drop.
    for (int i = 2; i <= 5; i++) queue_pulse(i);
    t = model_ts;
    i_level = 1'b1;
    repeat (6) tick();
    i_level = 1'b0;
    i_ready = 1'b1;
    check("pp_head_ts", 64'(o_timestamp), 64'(exp_ts_q.pop_front()));
    void'(exp_tot_q.pop_front());
    tick();
    i_ready = 1'b0;
    exp_ts_q.push_back(t);
    exp_tot_q.push_back(4'd6);
    check("pp_drop", 64'(o_drop_count), 64'(2));
    drain("pp");

    // Abort mid-pulse, then abort coinciding with the falling edge.
    i_ready = 1'b1;
    i_level = 1'b1;
    tick();
    tick();
    check("abort_busy", 64'(o_busy), 64'(1));
    i_enable = 1'b0;
    tick();
    check("abort_idle", 64'(o_busy), 64'(0));
    i_level = 1'b0;
    i_enable = 1'b1;
    tick();
    check("abort_valid", 64'(o_valid), 64'(0));
    i_level = 1'b1;
    repeat (3) tick();
    i_level = 1'b0;
    i_enable = 1'b0;
    tick();
    i_enable = 1'b1;
    tick();
    check("abort_fall_valid", 64'(o_valid), 64'(0));

    // Reset mid-pulse with two records queued and a nonzero drop count.
    i_ready = 1'b0;
    pulse(3, t);
    pulse(4, t);
    check("prerst_valid", 64'(o_valid), 64'(1));
    i_level = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("midrst_valid", 64'(o_valid), 64'(0));
    check("midrst_drop", 64'(o_drop_count), 64'(0));
    check("midrst_busy", 64'(o_busy), 64'(0));
    rst = 1'b0;
    repeat (4) tick();
    check("held_busy", 64'(o_busy), 64'(0));
    i_level = 1'b0;
    tick();
    tick();
    check("held_valid", 64'(o_valid), 64'(0));

    // Timestamp restarts at 0: first possible rise samples ts_now = 1.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    i_ready = 1'b1;
    tick();
    pulse(3, t);
    check("restart_ts", 64'(o_timestamp), 64'(1));
    check("restart_tot", 64'(o_tot), 64'(3));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_timestamper.md
# hit_timestamper

Downstream consumer of the two-flop input synchronizer in the muon DAQ front end. Takes one synchronized discriminator level and detects pulses on it. For each pulse it records the rising-edge timestamp from a free-running counter and the time-over-threshold (TOT) in clock cycles. Completed hit records are buffered in a small FIFO and offered to the readout/packer stage over a valid/ready handshake.

## Interface
Parameters:
- TS_WIDTH, 32: width of the free-running timestamp counter and of the record timestamp.
- TOT_WIDTH, 8: width of the TOT field. TOT saturates at 2^TOT_WIDTH-1.
- MIN_TOT, 2: minimum TOT in cycles for a pulse to be recorded. Shorter pulses are discarded as glitches. Legal range 1..2^TOT_WIDTH-1.
- FIFO_DEPTH, 4: record FIFO depth. Must be a power of two, ≥2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- i_level, input, 1: synchronized discriminator level, already in the clk domain.
- i_enable, input, 1: arm. When low, no new pulse starts and any in-progress pulse is aborted.
- o_valid, output, 1: FIFO head record is valid.
- i_ready, input, 1: consumer accepts the head record.
- o_timestamp, output, TS_WIDTH: head record rising-edge timestamp.
- o_tot, output, TOT_WIDTH: head record TOT in cycles.
- o_saturated, output, 1: head record TOT hit saturation.
- o_drop_count, output, 16: records lost because the FIFO was full. Saturates at 0xFFFF.
- o_busy, output, 1: FSM is in HIGH (a pulse is in progress).

## Operation
- Timestamp counter ts_now: 0 after reset, +1 every cycle, wraps modulo 2^TS_WIDTH. It runs regardless of i_enable.
- Edge detect: level_d is a 1-cycle delayed copy of i_level, reset to 1. Resetting to 1 means a level already high out of reset is not counted as an edge.
- Rise = i_level & ~level_d.
- FSM states are IDLE and HIGH.
- IDLE → HIGH when rise & i_enable:
  - cap_ts ← ts_now of that same cycle.
  - tot ← 1.
  - sat ← 0.
- HIGH, i_level=1, i_enable=1:
  - if tot = max, tot holds and sat ← 1.
  - otherwise tot ← tot+1.
- HIGH, i_level=0 (falling edge): → IDLE.
  - If tot ≥ MIN_TOT, push {cap_ts, tot, sat}.
  - Else discard silently; o_drop_count is not affected.
- HIGH, i_enable=0: → IDLE. Discard the pulse, no push. Abort takes priority over a falling edge in the same cycle.
- Push while FIFO full:
  - Record dropped; o_drop_count +1 (saturating).
  - Exception: if a pop happens in the same cycle, the push is accepted.
- Pop: o_valid & i_ready. The head advances.
- A rise in the same cycle as a falling-edge push is impossible, because i_level is a single bit. The earliest re-trigger is the cycle after the return to IDLE.
- Reset values:
  - o_valid=0, o_timestamp=0, o_tot=0, o_saturated=0.
  - o_drop_count=0, o_busy=0.
  - FSM=IDLE, FIFO empty.
- Reset mid-pulse or with a non-empty FIFO: all contents are lost and no record is emitted.

## Timing
- Rise sampled in cycle k → o_busy=1 in cycle k+1. The record timestamp is ts_now(k).
- Level high for N sampled cycles k..k+N-1, low at k+N → record TOT = min(N, 2^TOT_WIDTH-1).
- Record pushed at the end of cycle k+N. o_valid=1 from cycle k+N+1 if the FIFO was empty.
- Record data outputs come from FIFO registers and are stable while o_valid=1 & i_ready=0.
- Throughput: one pop per cycle. At most one push per 2 cycles, which follows from the input pulse structure.
- Output ports have no combinational path from i_level. i_ready affects only the next-cycle state.

## Structure
- Package hit_pkg contains:
  - hit_t, a packed struct {timestamp, tot, saturated} sized from the package-level TS_WIDTH/TOT_WIDTH defaults.
  - state_t, an enum {IDLE, HIGH}.
- Sub-module hit_fifo: synchronous FIFO with parameterized depth and width. It provides full/empty, push/pop and same-cycle push+pop when full. Outputs are registered.
- The top level contains the counter, edge detect, FSM, drop counter and hit_fifo instance.

## Test plan
- Single pulse: reset, run 10 cycles, drive i_level high for 5 cycles with i_ready=1 → one record, timestamp = ts_now at the first high sample, tot=5, saturated=0.
- Glitch filtering (MIN_TOT=2): 1-cycle pulse → no o_valid. 2-cycle pulse → record with tot=2.
- Saturation (TOT_WIDTH=4): 20-cycle pulse → tot=15, saturated=1.
- Backpressure and full FIFO (depth 4): i_ready=0, send 6 valid pulses → 4 records held in order, o_drop_count=2.
  - Then set i_ready=1 → the 4 records drain in arrival order with correct timestamps.
- Simultaneous push+pop at full: FIFO full, i_ready=1 in the push cycle → new record accepted, o_drop_count unchanged.
- Abort and reset: drop i_enable mid-pulse → no record, o_busy=0 next cycle. Assert rst mid-pulse with 2 records queued → o_valid=0, o_drop_count=0, ts restarts at 0. A level held high through reset release produces no record.
